// File: rtl/pll_clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pll_clk_ctrl_pkg
// Shared types and default constants for the PLL power-up sequencer and lock
// monitor (pll_clk_ctrl) and its period meter (pll_period_meter).
//   pcc_state_e : controller FSM state encoding
//   PCC_*       : default parameter values used by pll_clk_ctrl
// ---------------------------------------------------------------------------
package pll_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    PCC_IDLE    = 3'd0,
    PCC_SETTLE  = 3'd1,
    PCC_MEASURE = 3'd2,
    PCC_LOCKED  = 3'd3,
    PCC_FAULT   = 3'd4
  } pcc_state_e;

  localparam int PCC_CNT_W      = 16;
  localparam int PCC_TMO_W      = 20;
  localparam int PCC_SETTLE_CYC = 1024;
  localparam int PCC_LOCK_TMO   = 500000;
  localparam int PCC_TOL        = 2;
  localparam int PCC_LOCK_CNT   = 4;
  localparam int PCC_RETRY_WAIT = 256;
  localparam int PCC_MAX_RETRY  = 3;

endpackage

// File: rtl/pll_clk_ctrl_period_meter.sv
// ---------------------------------------------------------------------------
// pll_period_meter
// Measures the period of an asynchronous clock in cycles of clk.
//   clk, resetn : controller clock, async active-low reset
//   sig_i       : asynchronous clock to measure
//   hold_i      : forces the valid flag clear (measurement not in use)
//   ack_i       : consumer has taken the current period; clears valid
//   per_o       : last complete period (all-ones = saturated / too long)
//   valid_o     : a new period has been latched since the last ack
//   sat_o       : single-cycle pulse when the running counter saturates
// ---------------------------------------------------------------------------
module pll_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sig_i,
  input  logic             hold_i,
  input  logic             ack_i,
  output logic [CNT_W-1:0] per_o,
  output logic             valid_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // [0],[1] are the synchronizer; [2] holds the previous synchronized value.
  logic [2:0]       sync_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             valid_q, valid_d;

  assign rise = sync_q[1] & ~sync_q[2];

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    valid_d = valid_q;
    if (rise) begin
      per_d = cnt_q;
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // A fresh edge wins over an ack in the same cycle so no period is lost.
    if (hold_i)     valid_d = 1'b0;
    else if (rise)  valid_d = 1'b1;
    else if (ack_i) valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would chain the
  // synchronizer stages into a single flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], sig_i};
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      valid_q <= valid_d;
    end
  end

  assign per_o   = per_q;
  assign valid_o = valid_q;
  // Fires once on the step into saturation; a stopped clock reports a loss
  // even though no edge will ever latch a period.
  assign sat_o   = ~rise & (cnt_q == (CNT_MAX - CNT_ONE));

endmodule

// File: rtl/pll_clk_ctrl.sv
// ---------------------------------------------------------------------------
// pll_clk_ctrl
// PLL power-up sequencer and lock monitor. Enables the VCO on request, waits
// a settle time, then compares REF and FB periods (measured in clk cycles)
// and declares lock after LOCK_CNT consecutive matches.
//   clk, resetn : always-on controller clock, async active-low reset
//   req         : level request to run the PLL
//   ref_in      : asynchronous PLL reference clock
//   fb_in       : asynchronous PLL output divided by 8
//   en_vco      : VCO enable
//   locked      : lock indication
//   fault       : lock timeout, sticky until req falls
//   lock_lost   : one-cycle pulse when lock drops while req is high
//   ref_per     : last complete REF period
//   fb_per      : last complete FB period
// Build option: define PLL_CLK_CTRL_RETRY_EN to retry MAX_RETRY times, with
// the VCO off for RETRY_WAIT cycles, before declaring a sticky fault.
// ---------------------------------------------------------------------------
module pll_clk_ctrl
  import pll_clk_ctrl_pkg::*;
#(
  parameter int CNT_W      = PCC_CNT_W,
  parameter int TMO_W      = PCC_TMO_W,
  parameter int SETTLE_CYC = PCC_SETTLE_CYC,
  parameter int LOCK_TMO   = PCC_LOCK_TMO,
  parameter int TOL        = PCC_TOL,
  parameter int LOCK_CNT   = PCC_LOCK_CNT
`ifdef PLL_CLK_CTRL_RETRY_EN
  ,
  parameter int RETRY_WAIT = PCC_RETRY_WAIT,
  parameter int MAX_RETRY  = PCC_MAX_RETRY
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             en_vco,
  output logic             locked,
  output logic             fault,
  output logic             lock_lost,
  output logic [CNT_W-1:0] ref_per,
  output logic [CNT_W-1:0] fb_per
);

  localparam int               MC_W    = $clog2(LOCK_CNT + 1);
  localparam logic [TMO_W-1:0] TMO_ONE = 1;
  localparam logic [MC_W-1:0]  MC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pcc_state_e       state_q, state_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [MC_W-1:0]  match_q, match_d;
  logic             lock_lost_q;

`ifdef PLL_CLK_CTRL_RETRY_EN
  localparam int              RC_W   = $clog2(MAX_RETRY + 1);
  localparam logic [RC_W-1:0] RC_ONE = 1;
  logic [RC_W-1:0] retry_q, retry_d;
  logic            retry_done;
  assign retry_done = (retry_q == RC_W'(MAX_RETRY));
`endif

  // ---------------- period measurement ----------------
  logic hold, cmp_fire;
  logic ref_valid, fb_valid, ref_sat, fb_sat;

  // Flags are only meaningful while comparisons are being acted upon.
  assign hold     = !((state_q == PCC_MEASURE) || (state_q == PCC_LOCKED));
  assign cmp_fire = ref_valid & fb_valid;

  pll_period_meter #(.CNT_W(CNT_W)) u_ref_meter (
    .clk     (clk),
    .resetn  (resetn),
    .sig_i   (ref_in),
    .hold_i  (hold),
    .ack_i   (cmp_fire),
    .per_o   (ref_per),
    .valid_o (ref_valid),
    .sat_o   (ref_sat)
  );

  pll_period_meter #(.CNT_W(CNT_W)) u_fb_meter (
    .clk     (clk),
    .resetn  (resetn),
    .sig_i   (fb_in),
    .hold_i  (hold),
    .ack_i   (cmp_fire),
    .per_o   (fb_per),
    .valid_o (fb_valid),
    .sat_o   (fb_sat)
  );

  // ---------------- comparison ----------------
  logic [CNT_W:0] abs_diff;
  logic           per_ok, match_ev, mismatch_ev;

  always_comb begin
    if (ref_per >= fb_per) abs_diff = {1'b0, ref_per} - {1'b0, fb_per};
    else                   abs_diff = {1'b0, fb_per} - {1'b0, ref_per};
    per_ok      = (abs_diff <= (CNT_W+1)'(TOL)) &&
                  (ref_per != CNT_MAX) && (fb_per != CNT_MAX);
    match_ev    = cmp_fire & per_ok & ~ref_sat & ~fb_sat;
    mismatch_ev = (cmp_fire & ~per_ok) | ref_sat | fb_sat;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= PCC_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (!req) begin
      state_d = PCC_IDLE;
    end else begin
      unique case (state_q)
        PCC_IDLE:    state_d = PCC_SETTLE;
        PCC_SETTLE:  if (timer_q == TMO_W'(SETTLE_CYC - 1)) state_d = PCC_MEASURE;
        PCC_MEASURE: begin
          if (match_ev && (match_q == MC_W'(LOCK_CNT - 1))) state_d = PCC_LOCKED;
          else if (timer_q == TMO_W'(LOCK_TMO - 1))        state_d = PCC_FAULT;
        end
        PCC_LOCKED:  if (mismatch_ev) state_d = PCC_MEASURE;
        PCC_FAULT: begin
`ifdef PLL_CLK_CTRL_RETRY_EN
          if (!retry_done && (timer_q == TMO_W'(RETRY_WAIT - 1))) state_d = PCC_SETTLE;
`endif
        end
        default:     state_d = PCC_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    en_vco = (state_q == PCC_SETTLE) || (state_q == PCC_MEASURE) ||
             (state_q == PCC_LOCKED);
    locked = (state_q == PCC_LOCKED);
`ifdef PLL_CLK_CTRL_RETRY_EN
    fault  = (state_q == PCC_FAULT) && retry_done;
`else
    fault  = (state_q == PCC_FAULT);
`endif
  end

  assign lock_lost = lock_lost_q;

  // ---------------- timers and counters ----------------
  always_comb begin
    // The timer runs continuously from SETTLE entry through MEASURE so the
    // lock timeout includes the settle time; any other transition restarts it.
    if ((state_d != state_q) &&
        !((state_q == PCC_SETTLE) && (state_d == PCC_MEASURE)))
      timer_d = '0;
    else
      timer_d = timer_q + TMO_ONE;

    match_d = match_q;
    if (state_d != state_q)                      match_d = '0;
    else if ((state_q == PCC_MEASURE) && mismatch_ev) match_d = '0;
    else if ((state_q == PCC_MEASURE) && match_ev)    match_d = match_q + MC_ONE;

`ifdef PLL_CLK_CTRL_RETRY_EN
    retry_d = retry_q;
    if (state_q == PCC_IDLE)                                    retry_d = '0;
    else if ((state_q == PCC_FAULT) && (state_d == PCC_SETTLE)) retry_d = retry_q + RC_ONE;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q     <= '0;
      match_q     <= '0;
      lock_lost_q <= 1'b0;
`ifdef PLL_CLK_CTRL_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      timer_q     <= timer_d;
      match_q     <= match_d;
      // A req drop goes to IDLE, not MEASURE, so it never pulses.
      lock_lost_q <= (state_q == PCC_LOCKED) && (state_d == PCC_MEASURE);
`ifdef PLL_CLK_CTRL_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

endmodule
